// File: rtl/key_led_ctrl.sv
// key_led_ctrl: per-channel key synchroniser/debouncer with press pulses and mode-selected LED drive
module key_led_ctrl #(
  parameter int          CH_NUM    = 4,
  parameter logic [19:0] CNT_MAX   = 20'd999_999,
  parameter logic [24:0] BLINK_MAX = 25'd24_999_999,
  parameter logic        LED_ON    = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CH_NUM-1:0] key_in,
  input  logic [1:0]        mode,
  output logic [CH_NUM-1:0] key_flag,
  output logic [CH_NUM-1:0] key_state,
  output logic [CH_NUM-1:0] led_out
);
  localparam int CW = (CNT_MAX == '0) ? 1 : $clog2(int'(CNT_MAX) + 1);
  localparam int BW = (BLINK_MAX == '0) ? 1 : $clog2(int'(BLINK_MAX) + 1);
  localparam logic [CW-1:0] CMAX = CW'(CNT_MAX);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_MAX);
  logic [CH_NUM-1:0] s1, s2, stable, toggle_q, src;
  logic [CW-1:0] cnt [CH_NUM];
  logic [BW-1:0] bcnt;
  logic phase;
  assign stable = ~key_state;
  // two-flop synchroniser, idles at the released level
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  // debounce: stable level flips after CNT_MAX+1 consecutive differing samples; press emits a pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      for (int k = 0; k < CH_NUM; k++) cnt[k] <= '0;
      key_flag  <= '0;
      key_state <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        key_flag[k] <= 1'b0;
        if (s2[k] == stable[k]) cnt[k] <= '0;
        else if (cnt[k] == CMAX) begin
          cnt[k]       <= '0;
          key_state[k] <= ~s2[k];
          key_flag[k]  <= ~s2[k];
        end else cnt[k] <= cnt[k] + 1'b1;
      end
    end
  // toggle latch flips on every press pulse regardless of mode
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) toggle_q <= '0;
    else toggle_q <= toggle_q ^ key_flag;
  // shared blink timebase: phase inverts each BLINK_MAX+1 cycles
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BMAX) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else bcnt <= bcnt + 1'b1;
  // lit-pattern selected by mode
  always_comb
    src = (mode == 2'd0) ? key_state :
          (mode == 2'd1) ? toggle_q :
          (mode == 2'd2) ? (toggle_q & {CH_NUM{phase}}) : '0;
  // registered LED drive with fixed polarity
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) led_out <= {CH_NUM{~LED_ON}};
    else led_out <= LED_ON ? src : ~src;
endmodule
